// File: rtl/qenc_pkg.sv
// Shared constants and helpers for the quadrature encoder emulator:
// register map, CTRL bit positions, minimum tick period and the A/B step table.
package qenc_pkg;

    localparam logic [1:0] ADDR_CTRL     = 2'd0;
    localparam logic [1:0] ADDR_PERIOD   = 2'd1;
    localparam logic [1:0] ADDR_POSITION = 2'd2;
    localparam logic [1:0] ADDR_STEPS    = 2'd3;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_DIR      = 1;
    localparam int CTRL_CLEAR    = 2;
    localparam int CTRL_INDEX_EN = 3;

    localparam logic [31:0] MIN_PERIOD = 32'd2;

    // Next {A,B} pair: forward walks 00,10,11,01 so A leads B; reverse walks it backwards.
    function automatic logic [1:0] qenc_next_ab(input logic [1:0] ab, input logic reverse);
        logic [1:0] nxt;
        nxt = 2'b00;
        if (!reverse) begin
            unique case (ab)
                2'b00: nxt = 2'b10;
                2'b10: nxt = 2'b11;
                2'b11: nxt = 2'b01;
                2'b01: nxt = 2'b00;
                default: nxt = 2'b00;
            endcase
        end else begin
            unique case (ab)
                2'b00: nxt = 2'b01;
                2'b01: nxt = 2'b11;
                2'b11: nxt = 2'b10;
                2'b10: nxt = 2'b00;
                default: nxt = 2'b00;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/qenc_tick_gen.sv
// Tick counter that divides clk by max(period,2) and strobes edge_stb on wrap.
// The counter is held at 0 whenever enable is low.
module qenc_tick_gen
    import qenc_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] period,
    output logic        edge_stb
);

    logic [31:0] tick_cnt;
    logic [31:0] limit;

    // ">=" rather than "==" so a period shrunk below the running count fires at once.
    always_comb begin
        limit = (period < MIN_PERIOD) ? (MIN_PERIOD - 32'd1) : (period - 32'd1);
    end

    assign edge_stb = enable && (tick_cnt >= limit);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (!enable || edge_stb) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/quad_encoder_emulator.sv
// Avalon-MM controlled quadrature encoder emulator: generates A/B/Z at a
// programmable rate, tracks signed position and supports finite step bursts.
module quad_encoder_emulator
    import qenc_pkg::*;
#(
    parameter int CPR = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        enc_a,
    output logic        enc_b,
    output logic        enc_z
);

    localparam int REV_COUNTS = 4 * CPR;
    localparam int REV_W      = (REV_COUNTS > 1) ? $clog2(REV_COUNTS) : 1;
    localparam logic [REV_W-1:0] REV_LAST = REV_W'(REV_COUNTS - 1);

    logic               ctrl_enable, ctrl_dir, ctrl_index_en;
    logic [31:0]        period;
    logic [31:0]        remaining;
    logic               step_mode;
    logic signed [31:0] position;
    logic [REV_W-1:0]   rev_cnt;
    logic [1:0]         ab;

    logic               enable_d, dir_d, index_en_d;
    logic [31:0]        period_d;
    logic [31:0]        remaining_d;
    logic               step_mode_d;
    logic signed [31:0] position_d;
    logic [REV_W-1:0]   rev_cnt_d;
    logic [1:0]         ab_d;
    logic               enc_z_d;
    logic [31:0]        rd_mux;

    logic edge_stb;
    logic wr_ctrl, wr_period, wr_steps;

    assign wr_ctrl   = avs_write && (avs_address == ADDR_CTRL);
    assign wr_period = avs_write && (avs_address == ADDR_PERIOD);
    assign wr_steps  = avs_write && (avs_address == ADDR_STEPS);

    qenc_tick_gen u_tick_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (ctrl_enable),
        .period   (period),
        .edge_stb (edge_stb)
    );

    // NOTE: every next-state variable is given its hold value first, so no latch is inferred.
    always_comb begin
        enable_d    = ctrl_enable;
        dir_d       = ctrl_dir;
        index_en_d  = ctrl_index_en;
        period_d    = period;
        remaining_d = remaining;
        step_mode_d = step_mode;
        position_d  = position;
        rev_cnt_d   = rev_cnt;
        ab_d        = ab;

        // Direction is sampled here, at the edge, so a dir change never splits a period.
        if (edge_stb) begin
            ab_d = qenc_next_ab(ab, ctrl_dir);
            if (!ctrl_dir) begin
                position_d = position + 32'sd1;
                rev_cnt_d  = (rev_cnt == REV_LAST) ? '0 : rev_cnt + REV_W'(1);
            end else begin
                position_d = position - 32'sd1;
                rev_cnt_d  = (rev_cnt == '0) ? REV_LAST : rev_cnt - REV_W'(1);
            end
            if (step_mode && (remaining != 32'd0)) begin
                remaining_d = remaining - 32'd1;
                if (remaining == 32'd1) begin
                    step_mode_d = 1'b0;
                    enable_d    = 1'b0;
                end
            end
        end

        if (wr_period) begin
            period_d = avs_writedata;
        end

        if (wr_steps) begin
            remaining_d = avs_writedata;
            step_mode_d = (avs_writedata != 32'd0);
        end

        // Bus writes to CTRL override the burst-complete enable clear and any edge in flight.
        if (wr_ctrl) begin
            enable_d   = avs_writedata[CTRL_ENABLE];
            dir_d      = avs_writedata[CTRL_DIR];
            index_en_d = avs_writedata[CTRL_INDEX_EN];
            if (avs_writedata[CTRL_CLEAR]) begin
                position_d = '0;
                rev_cnt_d  = '0;
                ab_d       = 2'b00;
            end
        end

        enc_z_d = index_en_d && (rev_cnt_d == '0);
    end

    always_comb begin
        rd_mux = '0;
        unique case (avs_address)
            ADDR_CTRL: begin
                rd_mux[CTRL_ENABLE]   = ctrl_enable;
                rd_mux[CTRL_DIR]      = ctrl_dir;
                rd_mux[CTRL_INDEX_EN] = ctrl_index_en;
            end
            ADDR_PERIOD:   rd_mux = period;
            ADDR_POSITION: rd_mux = position;
            ADDR_STEPS:    rd_mux = remaining;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_enable   <= 1'b0;
            ctrl_dir      <= 1'b0;
            ctrl_index_en <= 1'b0;
            period        <= '0;
            remaining     <= '0;
            step_mode     <= 1'b0;
            position      <= '0;
            rev_cnt       <= '0;
            ab            <= 2'b00;
            enc_z         <= 1'b0;
        end else begin
            ctrl_enable   <= enable_d;
            ctrl_dir      <= dir_d;
            ctrl_index_en <= index_en_d;
            period        <= period_d;
            remaining     <= remaining_d;
            step_mode     <= step_mode_d;
            position      <= position_d;
            rev_cnt       <= rev_cnt_d;
            ab            <= ab_d;
            enc_z         <= enc_z_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

    assign enc_a = ab[1];
    assign enc_b = ab[0];

endmodule

// File: doc/quad_encoder_emulator.md
QUAD_ENCODER_EMULATOR -- requirements
Module: quad_encoder_emulator

Interface
REQ-001 SHALL have parameter CPR, default 1024, giving encoder lines per revolution (4*CPR counts per revolution).
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic is on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port avs_address, input, 2 bits: Avalon-MM slave word address.
REQ-005 SHALL have ports avs_read and avs_write, input, 1 bit each: Avalon-MM read and write strobes.
REQ-006 SHALL have port avs_writedata, input, 32 bits: write data.
REQ-007 SHALL have port avs_readdata, output, 32 bits: registered read data.
REQ-008 SHALL have ports enc_a, enc_b and enc_z, output, 1 bit each: emulated quadrature A, B and index conduit.

Function
REQ-009 SHALL implement the register map: 0 CTRL (RW), 1 PERIOD (RW), 2 POSITION (RO, signed 32-bit), 3 STEPS (RW).
REQ-010 SHALL decode the CTRL bits as follows:
- bit0 enable
- bit1 dir (0 = forward, 1 = reverse)
- bit2 clear (write-1 pulse, always reads 0)
- bit3 index_en
- other bits read 0
REQ-011 SHALL return avs_readdata exactly one cycle after avs_read; readdata holds its value otherwise; there are no wait states.
REQ-012 SHALL, while enable=1, run a tick counter from 0 up to max(PERIOD,2)-1 and produce one quadrature edge on wrap.
REQ-013 SHALL clear the tick counter to 0 and freeze enc_a, enc_b, enc_z and position while enable=0.
REQ-014 SHALL step {enc_a,enc_b} through 00,10,11,01,00 forward and through the reverse of that sequence when dir=1, so A leads B when forward.
REQ-015 SHALL increment POSITION by 1 per forward edge and decrement it by 1 per reverse edge, with 32-bit two's-complement wrap.
REQ-016 SHALL keep rev_cnt in 0..4*CPR-1:
- forward wraps 4*CPR-1 -> 0
- reverse wraps 0 -> 4*CPR-1
REQ-017 SHALL drive enc_z = index_en AND (rev_cnt==0).
REQ-018 SHALL apply a dir change at the next edge, never mid-period.
REQ-019 SHALL, when PERIOD is written while running, compare the tick counter against the new value; if the counter is at or above new max-1, the edge fires on the next cycle.
REQ-020 SHALL, on clear, set POSITION=0, rev_cnt=0 and {A,B}=00 in the next cycle; clear wins over a simultaneous edge.
REQ-021 SHALL handle STEPS writes as follows:
- a nonzero write N loads the remaining count and sets step_mode
- each edge decrements remaining
- the edge that brings remaining to 0 clears step_mode and CTRL.enable
- a write of 0 selects continuous mode
REQ-022 SHALL return remaining on a STEPS read.
REQ-023 SHALL give a CTRL write priority over the hardware enable clear when both occur in the same cycle.
REQ-024 SHALL ignore writes to address 2.

Reset
REQ-025 SHALL reset the following to 0 asynchronously on reset_n low:
- CTRL, PERIOD, STEPS and remaining
- step_mode and tick counter
- POSITION and rev_cnt
- enc_a, enc_b, enc_z and avs_readdata
REQ-026 SHALL release reset synchronously to clk; reset mid-operation aborts the sequence with no further edges.

Structure
REQ-027 SHALL place register addresses, CTRL bit indices and the minimum-period constant (2) in shared package qenc_pkg.
REQ-028 SHALL contain one sub-module, qenc_tick_gen, holding the tick counter and edge strobe.
REQ-029 SHALL keep register file, quadrature state, rev_cnt and position logic in the top module.

Verification
REQ-030 SHALL cover: PERIOD=4, CTRL=0x1 -> AB steps 00,10,11,01 every 4 clk; POSITION reads 8 after 32 clk.
REQ-031 SHALL cover: CTRL=0x3 from reset -> AB 00,01,11,10; POSITION reads -3 (0xFFFFFFFD) after 3 edges.
REQ-032 SHALL cover: CPR=4, index_en set, forward -> enc_z high for exactly one edge period every 16 edges; reverse wraps 0 -> 15 correctly.
REQ-033 SHALL cover: STEPS=5, PERIOD=2, enable -> exactly 5 edges, then CTRL reads 0x0, STEPS reads 0, outputs hold.
REQ-034 SHALL cover: clear written on the same cycle as an edge -> POSITION=0, AB=00; PERIOD=0 or 1 behaves as 2.
REQ-035 SHALL cover: reset_n low mid-run (PERIOD=10, after 7 edges) -> all outputs 0 asynchronously, no edges until re-enabled.
